// File: rtl/sort_floats_seq_pkg.sv
// Shared types and widths for the sequential float sorter.
package sort_floats_seq_pkg;

  localparam int unsigned FLEN = 64;
  localparam int unsigned NE   = 11;

  typedef enum logic [1:0] {
    StLoad,
    StSort,
    StDrain
  } state_e;

endpackage

// File: rtl/f_less_or_equal.sv
// Combinational IEEE-754 a <= b on sign-magnitude encodings; -0 and +0 compare equal.
module f_less_or_equal
  import sort_floats_seq_pkg::*;
(
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic            le_o
);

  logic            sign_a, sign_b;
  logic [FLEN-2:0] mag_a, mag_b;

  assign sign_a = a_i[FLEN-1];
  assign sign_b = b_i[FLEN-1];
  assign mag_a  = a_i[FLEN-2:0];
  assign mag_b  = b_i[FLEN-2:0];

  always_comb begin
    if (mag_a == '0 && mag_b == '0) begin
      le_o = 1'b1;
    end else if (sign_a != sign_b) begin
      le_o = sign_a;
    end else if (!sign_a) begin
      le_o = (mag_a <= mag_b);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      le_o = (mag_a >= mag_b);
    end
  end

endmodule

// File: rtl/sort_floats_seq.sv
// Loads N floats, bubble-sorts them one compare-and-swap per cycle, then drains ascending.
// Optional early exit on a swap-free pass: define SORT_FLOATS_SEQ_EARLY_EXIT_EN.
module sort_floats_seq
  import sort_floats_seq_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [FLEN-1:0] up_data,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  output logic            down_err
);

  localparam int unsigned     CntW    = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 2);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic [CntW-1:0] pass_q, pass_d;
  logic            err_q, err_d;
  logic [FLEN-1:0] elem_q [N];
  logic [FLEN-1:0] elem_d [N];
  logic            le;
  logic            is_special;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
  logic            swapped_q, swapped_d;
`endif

  // Inf and NaN share the all-ones exponent.
  assign is_special = &up_data[FLEN-2 -: NE];

  f_less_or_equal u_cmp (
    .a_i  (elem_q[idx_q]),
    .b_i  (elem_q[idx_q + CntW'(1)]),
    .le_o (le)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    err_d   = err_q;
    elem_d  = elem_q;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (up_valid) begin
          elem_d[cnt_q] = up_data;
          err_d         = err_q | is_special;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            idx_d   = '0;
            pass_d  = '0;
            state_d = err_d ? StDrain : StSort;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StSort: begin
        if (!le) begin
          elem_d[idx_q]              = elem_q[idx_q + CntW'(1)];
          elem_d[idx_q + CntW'(1)]   = elem_q[idx_q];
        end
        if (idx_q == LastIdx) begin
          idx_d  = '0;
          pass_d = pass_q + CntW'(1);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
          swapped_d = 1'b0;
          if (pass_q == LastIdx || !(swapped_q || !le)) state_d = StDrain;
`else
          if (pass_q == LastIdx) state_d = StDrain;
`endif
        end else begin
          idx_d = idx_q + CntW'(1);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
          swapped_d = swapped_q | !le;
`endif
        end
      end
      StDrain: begin
        if (down_ready) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StLoad;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    up_ready   = (state_q == StLoad);
    down_valid = (state_q == StDrain);
    down_data  = (state_q == StDrain) ? elem_q[cnt_q] : '0;
    down_last  = (state_q == StDrain) && (cnt_q == LastCnt);
    down_err   = (state_q == StDrain) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
      elem_q  <= '{default: '0};
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      elem_q  <= elem_d;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_floats_seq.sv
// Self-checking bench for sort_floats_seq against a real-valued stable-sort reference.
module tb_sort_floats_seq;

  localparam int N = 4;
  localparam logic [63:0] PosInf = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NegInf = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] QNan   = 64'h7FF8_0000_0000_0001;
  localparam logic [63:0] NegZ   = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [63:0] up_data = '0;
  logic        down_valid;
  logic        down_ready = 1'b1;
  logic [63:0] down_data;
  logic        down_last;
  logic        down_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] stim     [N];
  logic [63:0] exp_data [N];
  bit          exp_err;
  int          exp_lat;
  logic [63:0] got_data [8];
  bit          got_last [8];
  bit          got_err  [8];
  int          got_beats, got_lat, hold_viol;
  bit          timed_out;

  always #5 clk = ~clk;

  sort_floats_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_err   (down_err)
  );

  // Reference: stable insertion sort on real values (so -0 == +0), arrival order on Inf/NaN.
  task automatic model_ref;
    real         r [N];
    real         tr;
    logic [63:0] tb;
    int          j, passes;
    bit          sw;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_data[i] = stim[i];
      r[i] = $bitstoreal(stim[i]);
      if (stim[i][62:52] == 11'h7FF) exp_err = 1'b1;
    end
    if (exp_err) begin
      exp_lat = 1;
    end else begin
      for (int i = 1; i < N; i++) begin
        j = i;
        while (j > 0 && r[j-1] > r[j]) begin
          tr = r[j]; r[j] = r[j-1]; r[j-1] = tr;
          tb = exp_data[j]; exp_data[j] = exp_data[j-1]; exp_data[j-1] = tb;
          j--;
        end
      end
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
      for (int i = 0; i < N; i++) r[i] = $bitstoreal(stim[i]);
      passes = 0;
      for (int p = 0; p < N - 1; p++) begin
        sw = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
          if (r[i] > r[i+1]) begin
            tr = r[i]; r[i] = r[i+1]; r[i+1] = tr; sw = 1'b1;
          end
        end
        passes++;
        if (!sw) break;
      end
      exp_lat = passes * (N - 1) + 1;
`else
      passes  = N - 1;
      exp_lat = passes * (N - 1) + 1;
`endif
    end
  endtask

  task automatic drive_inputs;
    int wait_cyc;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      up_valid = 1'b1;
      up_data  = stim[i];
      wait_cyc = 0;
      while (!up_ready && wait_cyc < 50) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (wait_cyc >= 50) timed_out = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    up_valid = 1'b0;
    up_data  = '0;
  endtask

  // Records output beats; mode 0 always ready, 1 ready pattern 1,0,0,1 in DRAIN, 2 random.
  task automatic collect(input int mode, input bit junk);
    int          cyc, dcnt;
    bit          dr, v, prev_stall;
    logic [63:0] d, prev_data;
    cyc = 0; dcnt = 0; prev_stall = 1'b0; prev_data = '0;
    got_beats = 0; got_lat = -1; hold_viol = 0;
    while (cyc < 400) begin
      if (got_beats > 0 && got_last[got_beats-1]) break;
      if (got_beats >= N) break;
      if (junk) begin
        up_valid = 1'b1;
        up_data  = {32'hDEAD_BEEF, $urandom};
      end
      case (mode)
        0:       dr = 1'b1;
        1:       dr = (dcnt % 4 == 0) || (dcnt % 4 == 3);
        default: dr = 1'($urandom_range(0, 1));
      endcase
      down_ready = dr;
      if (prev_stall && (!down_valid || down_data !== prev_data)) hold_viol++;
      v = down_valid;
      d = down_data;
      if (v && dr) begin
        got_data[got_beats] = d;
        got_last[got_beats] = down_last;
        got_err[got_beats]  = down_err;
      end
      @(posedge clk);
      cyc++;
      if (v) dcnt++;
      if (v && dr) begin
        if (got_lat < 0) got_lat = cyc;
        got_beats++;
      end
      prev_stall = v && !dr;
      prev_data  = d;
      @(negedge clk);
    end
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b1;
    if (cyc >= 400) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({up_ready, down_valid, down_last, down_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000", {up_ready, down_valid, down_last, down_err});
    end
    checks++;
    if (down_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", down_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sort_example;
    logic [63:0] want [N];
    stim[0] = $realtobits(2.34); stim[1] = $realtobits(1.0);
    stim[2] = $realtobits(5.6e5); stim[3] = $realtobits(8e-7);
    want[0] = $realtobits(8e-7); want[1] = $realtobits(1.0);
    want[2] = $realtobits(2.34); want[3] = $realtobits(5.6e5);
    timed_out = 1'b0;
    drive_inputs();
    collect(0, 1'b0);
    checks++;
    if (got_beats !== N || timed_out) begin
      errors++;
      $display("FAIL example_beats: got %0d (timeout %0d) expected %0d", got_beats, timed_out, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== want[i] || got_last[i] !== (i == N - 1) || got_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL example_beat%0d: got %h last %0d err %0d expected %h last %0d err 0",
                 i, got_data[i], got_last[i], got_err[i], want[i], i == N - 1);
      end
    end
    checks++;
    if (got_lat !== 10) begin
      errors++;
      $display("FAIL example_latency: got %0d expected 10", got_lat);
    end
  endtask

  task automatic test_error_skip;
    stim[0] = $realtobits(1.0); stim[1] = PosInf;
    stim[2] = $realtobits(2.34); stim[3] = 64'd0;
    timed_out = 1'b0;
    drive_inputs();
    collect(0, 1'b0);
    checks++;
    if (got_beats !== N || timed_out || got_lat !== 1) begin
      errors++;
      $display("FAIL err_skip_timing: got beats %0d lat %0d expected beats %0d lat 1",
               got_beats, got_lat, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== stim[i] || got_err[i] !== 1'b1 || got_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL err_skip_beat%0d: got %h err %0d last %0d expected %h err 1",
                 i, got_data[i], got_err[i], got_last[i], stim[i]);
      end
    end
  endtask

  task automatic test_zeros;
    logic [63:0] want [N];
    stim[0] = 64'd0; stim[1] = NegZ; stim[2] = $realtobits(-1.0); stim[3] = NegZ;
    want[0] = $realtobits(-1.0); want[1] = 64'd0; want[2] = NegZ; want[3] = NegZ;
    timed_out = 1'b0;
    drive_inputs();
    collect(0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== want[i] || got_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL zeros_beat%0d: got %h err %0d expected %h err 0",
                 i, got_data[i], got_err[i], want[i]);
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < N; i++) stim[i] = $realtobits(real'($urandom_range(0, 999)) / 8.0);
    model_ref();
    timed_out = 1'b0;
    drive_inputs();
    collect(1, 1'b0);
    checks++;
    if (got_beats !== N || hold_viol !== 0 || timed_out) begin
      errors++;
      $display("FAIL stall_hold: got beats %0d hold_violations %0d expected beats %0d and 0",
               got_beats, hold_viol, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h expected %h", i, got_data[i], exp_data[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (down_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra_beat: got down_valid %0d expected 0", down_valid);
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    // Partial LOAD then reset.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      up_valid = 1'b1;
      up_data  = $realtobits(real'(100 + i));
    end
    @(negedge clk);
    up_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Full batch, then reset while sorting.
    for (int i = 0; i < N; i++) stim[i] = $realtobits(real'(5 + i));
    timed_out = 1'b0;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got valid %0d ready %0d expected 0 1", down_valid, up_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (down_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_stray: got %0d beats expected 0", stray);
    end
    for (int i = 0; i < N; i++) stim[i] = $realtobits(real'(3 - i));
    drive_inputs();
    collect(0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got_data[i] !== $realtobits(real'(i))) begin
        errors++;
        $display("FAIL reset_fresh_beat%0d: got %h expected %h",
                 i, got_data[i], $realtobits(real'(i)));
      end
    end
  endtask

  task automatic test_presorted;
    for (int i = 0; i < N; i++) stim[i] = $realtobits(real'(i + 1));
    model_ref();
    timed_out = 1'b0;
    drive_inputs();
    collect(0, 1'b0);
    checks++;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
    if (got_lat !== N) begin
      errors++;
      $display("FAIL presorted_latency: got %0d expected %0d", got_lat, N);
    end
`else
    if (got_lat !== (N - 1) * (N - 1) + 1) begin
      errors++;
      $display("FAIL presorted_latency: got %0d expected %0d", got_lat, (N - 1) * (N - 1) + 1);
    end
`endif
    checks++;
    if (got_data[0] !== exp_data[0] || got_data[N-1] !== exp_data[N-1]) begin
      errors++;
      $display("FAIL presorted_data: got %h..%h expected %h..%h",
               got_data[0], got_data[N-1], exp_data[0], exp_data[N-1]);
    end
  endtask

  task automatic test_random;
    int mode, bad;
    logic [63:0] v;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0:       v = 64'd0;
          1:       v = NegZ;
          2, 3:    v = $realtobits(real'($urandom_range(0, 3)));
          default: v = $realtobits((real'($urandom_range(0, 20000)) - 10000.0) / 64.0);
        endcase
        stim[i] = v;
      end
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       stim[$urandom_range(0, N - 1)] = PosInf;
          1:       stim[$urandom_range(0, N - 1)] = NegInf;
          default: stim[$urandom_range(0, N - 1)] = QNan;
        endcase
      end
      model_ref();
      mode = (b % 2 == 0) ? 0 : 2;
      timed_out = 1'b0;
      drive_inputs();
      collect(mode, b % 3 == 1);
      bad = 0;
      for (int i = 0; i < N; i++) begin
        if (got_data[i] !== exp_data[i] || got_err[i] !== exp_err ||
            got_last[i] !== (i == N - 1)) bad++;
      end
      checks++;
      if (bad !== 0 || got_beats !== N || timed_out) begin
        errors++;
        $display("FAIL random_batch%0d: got %h %h %h %h err %0d beats %0d expected %h %h %h %h err %0d",
                 b, got_data[0], got_data[1], got_data[2], got_data[3], got_err[0], got_beats,
                 exp_data[0], exp_data[1], exp_data[2], exp_data[3], exp_err);
      end
      if (mode == 0) begin
        checks++;
        if (got_lat !== exp_lat) begin
          errors++;
          $display("FAIL random_latency%0d: got %0d expected %0d", b, got_lat, exp_lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sort_example();
    test_error_skip();
    test_zeros();
    test_stall();
    test_reset_mid();
    test_presorted();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
